// File: rtl/rv32_data_bus_router.sv
// rv32_data_bus_router
//   Purpose : decodes each M-stage data access to local memory (zero latency),
//             one of NUM_SLAVES Wishbone-classic peripherals (multi-cycle,
//             stalls the pipeline) or an unmapped-address error response.
//   Latency : MEM/ERR add no cycles; a peripheral access takes launch + wait
//             cycles + ack + DONE = 3 cycles minimum.
//   Backpressure : stall_o holds F/D/E/M/W from launch until the DONE cycle.
//   Ports   : clk_i/rst_i (async active-high); req_* M-stage request;
//             stall_o, rdata_o, err_o back to the core; mem_we_o to local
//             memory; wb_* per-slave Wishbone-classic master channel.
//   Option  : define RV32_BUS_TIMEOUT_EN to abort a BUSY access after
//             TIMEOUT_CYCLES cycles without ack (err_o in DONE).
module rv32_data_bus_router #(
  parameter int         NUM_SLAVES     = 4,
  parameter logic [3:0] PERIPH_REGION  = 4'h2,
  parameter int         SLAVE_LSB      = 16,
  parameter int         TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [3:0]               req_we_i,
  input  logic [31:0]              req_addr_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     stall_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic [3:0]               mem_we_o,
  output logic [NUM_SLAVES-1:0]    wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    wb_stb_o,
  output logic                     wb_we_o,
  output logic [3:0]               wb_sel_o,
  output logic [31:0]              wb_adr_o,
  output logic [31:0]              wb_dat_o,
  input  logic [32*NUM_SLAVES-1:0] wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    wb_ack_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Whole field between the slave LSB and the region nibble; an index that
  // does not fit NUM_SLAVES (e.g. 5 with 4 slaves) must decode as an error
  // rather than alias onto a real slave through the low index bits.
  localparam int FLD_W = 28 - SLAVE_LSB;

`ifdef RV32_BUS_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Address decode (combinational)
  // ---------------------------------------------------------------------------
  logic [FLD_W-1:0] slv_field;
  logic [IDX_W-1:0] req_idx;
  logic             is_mem;
  logic             is_per;
  logic             is_err;

  assign slv_field = req_addr_i[27:SLAVE_LSB];
  assign req_idx   = IDX_W'(slv_field);
  assign is_mem    = (req_addr_i[31:29] == 3'b000);
  assign is_per    = (req_addr_i[31:28] == PERIPH_REGION) &&
                     (32'(slv_field) < 32'(NUM_SLAVES));
  assign is_err    = !is_mem && !is_per;

  // ---------------------------------------------------------------------------
  // State and latches
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] cyc_q, cyc_d;
  logic [IDX_W-1:0]      slv_q, slv_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  done_err;

`ifdef RV32_BUS_TIMEOUT_EN
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  to_err_q, to_err_d;
  assign done_err = to_err_q;
`else
  assign done_err = 1'b0;
`endif

  // Only the latched target's ack/data are ever looked at.
  logic                  sel_ack;
  logic [31:0]           sel_dat;
  logic [NUM_SLAVES-1:0] launch_cyc;

  always_comb begin
    sel_ack    = 1'b0;
    sel_dat    = 32'h0;
    launch_cyc = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_q == IDX_W'(i)) begin
        sel_ack = wb_ack_i[i];
        sel_dat = wb_dat_i[32*i +: 32];
      end
      launch_cyc[i] = (req_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      slv_q    <= '0;
      adr_q    <= 32'h0;
      dat_q    <= 32'h0;
      sel_q    <= 4'h0;
      rdata_q  <= 32'h0;
`ifdef RV32_BUS_TIMEOUT_EN
      cnt_q    <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      slv_q    <= slv_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
`ifdef RV32_BUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    slv_d    = slv_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
`ifdef RV32_BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_err_d = to_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && is_per) begin
          adr_d    = req_addr_i;
          dat_d    = req_wdata_i;
          sel_d    = req_we_i;
          slv_d    = req_idx;
          cyc_d    = launch_cyc;
          rdata_d  = 32'h0;
`ifdef RV32_BUS_TIMEOUT_EN
          cnt_d    = '0;
          to_err_d = 1'b0;
`endif
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // An ack arriving in the timeout cycle takes priority over the abort.
        if (sel_ack) begin
          rdata_d = sel_dat;
          cyc_d   = '0;
          state_d = ST_DONE;
        end
`ifdef RV32_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d  = 32'h0;
          cyc_d    = '0;
          to_err_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      // The core advances at this edge; the request still on the bus is the
      // one just served, so it is never relaunched from here.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Combinational outputs are gated by rst_i so the core sees a quiet
  // bus for the whole reset window, even while it keeps presenting a request.
  // ---------------------------------------------------------------------------
  assign stall_o  = !rst_i &&
                    (((state_q == ST_IDLE) && req_valid_i && is_per) ||
                     (state_q == ST_BUSY));
  assign mem_we_o = (!rst_i && req_valid_i && is_mem) ? req_we_i : 4'h0;
  assign err_o    = !rst_i &&
                    (((state_q == ST_IDLE) && req_valid_i && is_err) ||
                     ((state_q == ST_DONE) && done_err));
  assign rdata_o  = (!rst_i && (state_q == ST_DONE)) ? rdata_q : 32'h0;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = |sel_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_rv32_data_bus_router.sv
module tb_rv32_data_bus_router;

  localparam int NS = 4;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic [3:0]    req_we_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          stall_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [3:0]    mem_we_o;
  logic [NS-1:0] wb_cyc_o;
  logic [NS-1:0] wb_stb_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [32*NS-1:0] wb_dat_i;
  logic [NS-1:0] wb_ack_i;

  int n_vec = 0;
  int n_err = 0;

  rv32_data_bus_router #(
    .NUM_SLAVES(NS), .PERIPH_REGION(4'h2), .SLAVE_LSB(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .err_o(err_o), .mem_we_o(mem_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, want);
    end
  endtask

  // Reference decode: 0 = local memory, 1 = peripheral, 2 = error.
  function automatic int classify(input logic [31:0] addr, output int slv);
    int region = int'(addr >> 28);
    int field  = int'((addr >> 16) & 32'h0FFF);
    slv = field;
    if (region <= 1) return 0;
    if (region == 2 && field < NS) return 1;
    return 2;
  endfunction

  // Random traffic on every slave except the target (target ack held low).
  task automatic noise(input int target);
    for (int i = 0; i < NS; i++) wb_dat_i[32*i +: 32] = $urandom;
    wb_ack_i = NS'($urandom);
    if (target >= 0) wb_ack_i[target] = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, 32'(stall_o), 32'd0);
    chk({tag, ".err"},   32'(err_o),   32'd0);
    chk({tag, ".rdata"}, rdata_o,      32'd0);
    chk({tag, ".cyc"},   32'(wb_cyc_o), 32'd0);
  endtask

  task automatic chk_busy(input string tag, input int slv, input logic [31:0] addr,
                          input logic [3:0] we, input logic [31:0] wd);
    chk({tag, ".stall"}, 32'(stall_o),  32'd1);
    chk({tag, ".cyc"},   32'(wb_cyc_o), 32'd1 << slv);
    chk({tag, ".stb"},   32'(wb_stb_o), 32'd1 << slv);
    chk({tag, ".adr"},   wb_adr_o,      addr);
    chk({tag, ".sel"},   32'(wb_sel_o), 32'(we));
    chk({tag, ".we"},    32'(wb_we_o),  32'(we != 4'h0));
    chk({tag, ".dat"},   wb_dat_o,      wd);
    chk({tag, ".err"},   32'(err_o),    32'd0);
    chk({tag, ".memwe"}, 32'(mem_we_o), 32'd0);
  endtask

  // One complete access; 'delay' = cycles from launch to the target's ack.
  task automatic access(input string tag, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, input int delay, input logic [31:0] rd);
    int slv;
    int kind = classify(addr, slv);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_wdata_i = wd;
    noise(kind == 1 ? slv : -1);
    #1;
    if (kind == 0) begin
      chk({tag, ".mem.we"},    32'(mem_we_o), 32'(we));
      chk({tag, ".mem.stall"}, 32'(stall_o),  32'd0);
      chk({tag, ".mem.cyc"},   32'(wb_cyc_o), 32'd0);
      chk({tag, ".mem.err"},   32'(err_o),    32'd0);
    end else if (kind == 2) begin
      chk({tag, ".err.err"},   32'(err_o),    32'd1);
      chk({tag, ".err.stall"}, 32'(stall_o),  32'd0);
      chk({tag, ".err.cyc"},   32'(wb_cyc_o), 32'd0);
      chk({tag, ".err.memwe"}, 32'(mem_we_o), 32'd0);
      chk({tag, ".err.rdata"}, rdata_o,       32'd0);
    end else begin
      chk({tag, ".launch.stall"}, 32'(stall_o),  32'd1);
      chk({tag, ".launch.err"},   32'(err_o),    32'd0);
      chk({tag, ".launch.memwe"}, 32'(mem_we_o), 32'd0);
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk_i);
        noise(slv);
        if (k == delay) begin
          wb_ack_i[slv] = 1'b1;
          wb_dat_i[32*slv +: 32] = rd;
        end
        #1;
        chk_busy({tag, ".busy"}, slv, addr, we, wd);
      end
      @(negedge clk_i);
      noise(-1);
      #1;
      chk({tag, ".done.stall"}, 32'(stall_o),  32'd0);
      chk({tag, ".done.rdata"}, rdata_o,       rd);
      chk({tag, ".done.err"},   32'(err_o),    32'd0);
      chk({tag, ".done.cyc"},   32'(wb_cyc_o), 32'd0);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; req_we_i = 4'h0;
    noise(-1);
    #1;
    chk_quiet({tag, ".after"});
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          r;

    // Reset with a peripheral request already presented: everything quiet.
    rst_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 32'h2001_0000;
    req_we_i = 4'hF; req_wdata_i = 32'h5555_AAAA; noise(-1);
    #2;
    chk_quiet("reset.per");
    chk("reset.adr", wb_adr_o, 32'd0);
    chk("reset.sel", 32'(wb_sel_o), 32'd0);
    req_addr_i = 32'h1000_0000;
    #1;
    chk("reset.memwe", 32'(mem_we_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; req_valid_i = 1'b0;

    // Directed cases.
    access("store_mem", 32'h1000_0010, 4'hF, 32'h0BAD_BEEF, 0, 32'h0);
    access("load_s1",   32'h2001_0004, 4'h0, 32'h0,         2, 32'hCAFE_F00D);
    access("err_idx5",  32'h2005_0000, 4'h0, 32'h0,         0, 32'h0);
    access("err_reg3",  32'h3000_0000, 4'h0, 32'h0,         0, 32'h0);
    access("store_s3",  32'h2003_0100, 4'h3, 32'h1234_5678, 1, 32'h0);

    // Randomised mix against the reference decode.
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      w = (($urandom & 1) != 0) ? 4'($urandom) : 4'h0;
      if (r < 2)      a = $urandom & 32'h1FFF_FFFF;
      else if (r < 4) a = (($urandom & 1) != 0) ?
                          (32'h2000_0000 | (32'($urandom_range(4, 4095)) << 16) | ($urandom & 32'hFFFF)) :
                          ((32'($urandom_range(3, 15)) << 28) | ($urandom & 32'h0FFF_FFFF));
      else            a = 32'h2000_0000 | (32'($urandom_range(0, NS-1)) << 16) | ($urandom & 32'hFFFC);
      access("rand", a, w, $urandom, int'($urandom_range(1, 4)), $urandom);
    end

    // Target slave 0 stays silent while slave 2 acks every cycle.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h2000_0020; req_we_i = 4'h0; req_wdata_i = 32'h0;
    noise(0);
    #1;
    chk("hang.launch.stall", 32'(stall_o), 32'd1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk_i); noise(0); wb_ack_i[2] = 1'b1; #1;
      chk_busy("hang.busy", 0, 32'h2000_0020, 4'h0, 32'h0);
    end
`ifdef RV32_BUS_TIMEOUT_EN
    @(negedge clk_i); noise(0); #1;
    chk("hang.to.stall", 32'(stall_o),  32'd0);
    chk("hang.to.err",   32'(err_o),    32'd1);
    chk("hang.to.rdata", rdata_o,       32'd0);
    chk("hang.to.cyc",   32'(wb_cyc_o), 32'd0);
`else
    for (int k = TO + 1; k <= 20; k++) begin
      @(negedge clk_i); noise(0); wb_ack_i[2] = 1'b1; #1;
      chk("hang.wait.stall", 32'(stall_o),  32'd1);
      chk("hang.wait.cyc",   32'(wb_cyc_o), 32'd1);
    end
    @(negedge clk_i); noise(0); wb_ack_i[0] = 1'b1; wb_dat_i[31:0] = 32'h0F0F_1234; #1;
    chk("hang.ack.stall", 32'(stall_o), 32'd1);
    @(negedge clk_i); noise(-1); #1;
    chk("hang.done.rdata", rdata_o,     32'h0F0F_1234);
    chk("hang.done.err",   32'(err_o),  32'd0);
    chk("hang.done.stall", 32'(stall_o), 32'd0);
`endif
    @(negedge clk_i); req_valid_i = 1'b0; noise(-1); #1;
    chk_quiet("hang.after");

    // Asynchronous reset in the middle of a BUSY access to slave 3.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h2003_0008; req_we_i = 4'hF; req_wdata_i = 32'hDEAD_0001;
    noise(3);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk_i); noise(3); #1;
      chk("rstmid.busy.cyc", 32'(wb_cyc_o), 32'b1000);
    end
    @(negedge clk_i); noise(3); #1;
    rst_i = 1'b1;
    #1;
    chk_quiet("rstmid.async");
    chk("rstmid.stb", 32'(wb_stb_o), 32'd0);
    #1;
    rst_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i); noise(-1); wb_ack_i[3] = 1'b1; #1;
    chk_quiet("rstmid.idle");
    @(negedge clk_i); noise(-1); #1;
    chk_quiet("rstmid.idle2");

    // Normal traffic still works after the reset.
    access("post_rst", 32'h2002_0040, 4'h0, 32'h0, 3, 32'hA5A5_5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
